// File: rtl/fifo_wr_arbiter_if.sv
// Request/data bundle between N producers, the write arbiter and the FIFO write port.
// The slave modport is the arbiter's view; master is the producer/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_REQ  = 4
) ();
  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        i_req;
  logic [N_REQ*DATA_W-1:0] i_data;
  logic [N_REQ-1:0]        o_ack;
  logic                    o_fifo_wr_en;
  logic [DATA_W-1:0]       o_fifo_data;
  logic                    i_fifo_full;
  logic [IDX_W-1:0]        o_owner;
  logic                    o_busy;

  modport master (
    output i_req, i_data, i_fifo_full,
    input  o_ack, o_fifo_wr_en, o_fifo_data, o_owner, o_busy
  );

  modport slave (
    input  i_req, i_data, i_fifo_full,
    output o_ack, o_fifo_wr_en, o_fifo_data, o_owner, o_busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between N_REQ producers.
// Each grant writes up to MAX_BURST words, stalling on the FIFO full flag.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0]  winner_c;
  logic [IDX_W-1:0]  cand_c;
  logic              found_c;
  logic              own_req_c;
  logic [DATA_W-1:0] own_data_c;
  logic              wr_c;
  logic [N_REQ-1:0]  ack_c;

  // Scan requesters starting just after the last releaser, wrapping modulo N_REQ.
  always_comb begin : rr_pick
    winner_c = last_q;
    found_c  = 1'b0;
    cand_c   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand_c = IDX_W'((32'(last_q) + i) % N_REQ);
      if (!found_c && bus.i_req[cand_c]) begin
        winner_c = cand_c;
        found_c  = 1'b1;
      end
    end
  end

  // Select the current owner's request bit and data word.
  always_comb begin : owner_mux
    own_req_c  = 1'b0;
    own_data_c = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (owner_q == IDX_W'(k)) begin
        own_req_c  = bus.i_req[k];
        own_data_c = bus.i_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and write decision.
  always_comb begin : fsm_comb
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wr_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|bus.i_req) begin
          owner_d = winner_c;
          cnt_d   = '0;
          state_d = BURST;
        end
      end

      BURST: begin
        wr_c = own_req_c & ~bus.i_fifo_full;
        if (!own_req_c) begin
          last_d  = owner_q;
          state_d = IDLE;
        end else if (wr_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
            last_d  = owner_q;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Requester 0 gets first priority out of reset because last starts at N_REQ-1.
  always_ff @(posedge clk or negedge rst) begin : fsm_regs
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // One-hot ack for the owner only.
  always_comb begin : ack_decode
    ack_c = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      ack_c[k] = wr_c && (owner_q == IDX_W'(k));
    end
  end

  assign bus.o_ack        = ack_c;
  assign bus.o_fifo_wr_en = wr_c;
  assign bus.o_fifo_data  = (state_q == BURST) ? own_data_c : '0;
  assign bus.o_owner      = owner_q;
  assign bus.o_busy       = (state_q == BURST);

  a_no_write_when_full : assert property (
    @(posedge clk) disable iff (!rst) !(bus.o_fifo_wr_en && bus.i_fifo_full));

  a_ack_onehot : assert property (
    @(posedge clk) disable iff (!rst) $onehot0(bus.o_ack));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter: producer models, a FIFO model and a write scoreboard.
module tb_fifo_wr_arbiter;
  localparam int unsigned DW    = 16;
  localparam int unsigned NR    = 4;
  localparam int unsigned MB    = 8;
  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic [1:0]    own;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_W(DW), .N_REQ(NR)) ifc ();

  fifo_wr_arbiter #(.DATA_W(DW), .N_REQ(NR), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int            n_cmp = 0;
  int            n_err = 0;
  int            seq [NR];
  logic [NR-1:0] ack_q;
  logic          full_force;
  logic          use_fifo;
  logic          fifo_clr;
  wr_t           exp_q [$];
  logic [DW-1:0] mem_q [$];
  logic [DW-1:0] mem [DEPTH];
  int            fcount;
  int            wr_total;

  function automatic logic [DW-1:0] word_of(int k, int s);
    return {4'(k), 12'(s)};
  endfunction

  // FIFO model: drops writes when already holding DEPTH words.
  always @(posedge clk) begin
    if (fifo_clr) begin
      fcount   <= 0;
      wr_total <= 0;
    end else if (ifc.o_fifo_wr_en) begin
      wr_total <= wr_total + 1;
      if (fcount < int'(DEPTH)) begin
        mem[fcount] <= ifc.o_fifo_data;
        fcount      <= fcount + 1;
      end
    end
  end

  task automatic drive();
    for (int k = 0; k < int'(NR); k++) ifc.i_data[k*DW +: DW] = word_of(k, seq[k]);
    ifc.i_fifo_full = use_fifo ? (fcount >= int'(DEPTH)) : full_force;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    for (int k = 0; k < int'(NR); k++) if (ack_q[k]) seq[k]++;
  endtask

  task automatic smp();
    @(negedge clk);
    ack_q = ifc.o_ack;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    ifc.i_req  = '0;
    full_force = 1'b0;
    use_fifo   = 1'b0;
    fifo_clr   = 1'b1;
    ack_q      = '0;
    for (int k = 0; k < int'(NR); k++) seq[k] = 0;
    exp_q.delete();
    mem_q.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b1;
    fifo_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    fifo_clr   = 1'b1;
    full_force = 1'b0;
    use_fifo   = 1'b0;
    ifc.i_req  = 4'b1111;
    for (int k = 0; k < int'(NR); k++) seq[k] = 0;
    drive();
    repeat (2) @(posedge clk);
    smp();
    n_cmp++; if (ifc.o_fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got=%b exp=0", ifc.o_fifo_wr_en); end
    n_cmp++; if (ifc.o_ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack got=%b exp=0000", ifc.o_ack); end
    n_cmp++; if (ifc.o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", ifc.o_busy); end
    n_cmp++; if (ifc.o_owner !== 2'd0) begin n_err++; $display("FAIL reset_owner got=%0d exp=0", ifc.o_owner); end
    @(posedge clk);
    #1;
    rst      = 1'b1;
    fifo_clr = 1'b0;
    smp();
    n_cmp++; if (ifc.o_busy !== 1'b0) begin n_err++; $display("FAIL reset_arb_bubble busy got=%b exp=0", ifc.o_busy); end
    adv(); drive(); smp();
    n_cmp++; if (ifc.o_busy !== 1'b1 || ifc.o_owner !== 2'd0) begin
      n_err++; $display("FAIL reset_first_grant busy=%b owner=%0d exp busy=1 owner=0", ifc.o_busy, ifc.o_owner);
    end
  endtask

  task automatic test_round_robin();
    logic exp_wr;
    wr_t  e;
    do_reset();
    ifc.i_req = 4'b1111;
    for (int b = 0; b < 5; b++)
      for (int w = 0; w < int'(MB); w++) begin
        e.own  = 2'(b % 4);
        e.data = word_of(b % 4, ((b == 4) ? 8 : 0) + w);
        exp_q.push_back(e);
      end
    for (int c = 0; c < 45; c++) begin
      if (c != 0) adv();
      drive(); smp();
      exp_wr = (c % 9) != 0;
      n_cmp++; if (ifc.o_fifo_wr_en !== exp_wr) begin n_err++; $display("FAIL rr_wr_en c=%0d got=%b exp=%b", c, ifc.o_fifo_wr_en, exp_wr); end
      if (ifc.o_fifo_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL rr_extra_write c=%0d data=%h", c, ifc.o_fifo_data);
        end else begin
          e = exp_q.pop_front();
          n_cmp++; if (ifc.o_fifo_data !== e.data || ifc.o_owner !== e.own || ifc.o_ack !== (4'b0001 << e.own)) begin
            n_err++; $display("FAIL rr_word c=%0d data=%h owner=%0d ack=%b exp data=%h owner=%0d", c, ifc.o_fifo_data, ifc.o_owner, ifc.o_ack, e.data, e.own);
          end
        end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_missing got_left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_single_release();
    logic exp_wr;
    wr_t  e;
    do_reset();
    ifc.i_req = 4'b0100;
    for (int w = 0; w < 6; w++) begin e.own = 2'd2; e.data = word_of(2, w); exp_q.push_back(e); end
    for (int c = 0; c < 12; c++) begin
      if (c != 0) adv();
      if (c >= 8) ifc.i_req[2] = 1'b1;
      else if (seq[2] >= 3) ifc.i_req[2] = 1'b0;
      drive(); smp();
      exp_wr = (c >= 1 && c <= 3) || (c >= 9);
      n_cmp++; if (ifc.o_fifo_wr_en !== exp_wr) begin n_err++; $display("FAIL single_wr_en c=%0d got=%b exp=%b", c, ifc.o_fifo_wr_en, exp_wr); end
      if (ifc.o_fifo_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL single_extra_write c=%0d", c);
        end else begin
          e = exp_q.pop_front();
          n_cmp++; if (ifc.o_fifo_data !== e.data || ifc.o_ack !== 4'b0100) begin
            n_err++; $display("FAIL single_word c=%0d data=%h ack=%b exp data=%h ack=0100", c, ifc.o_fifo_data, ifc.o_ack, e.data);
          end
        end
      end else begin
        n_cmp++; if (ifc.o_ack !== 4'b0000) begin n_err++; $display("FAIL single_ack_idle c=%0d got=%b exp=0000", c, ifc.o_ack); end
      end
      if (c == 4) begin n_cmp++; if (ifc.o_busy !== 1'b1) begin n_err++; $display("FAIL single_release_busy got=%b exp=1", ifc.o_busy); end end
      if (c == 6) begin n_cmp++; if (ifc.o_busy !== 1'b0 || ifc.o_owner !== 2'd2) begin
        n_err++; $display("FAIL single_idle_hold busy=%b owner=%0d exp busy=0 owner=2", ifc.o_busy, ifc.o_owner); end end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL single_missing got_left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_stall();
    logic exp_wr;
    wr_t  e;
    do_reset();
    ifc.i_req = 4'b0001;
    for (int w = 0; w < 10; w++) begin e.own = 2'd0; e.data = word_of(0, w); exp_q.push_back(e); end
    for (int c = 0; c < 17; c++) begin
      if (c != 0) adv();
      full_force = (c >= 5 && c <= 9);
      drive(); smp();
      exp_wr = (c >= 1 && c <= 4) || (c >= 10 && c <= 13) || (c >= 15);
      n_cmp++; if (ifc.o_fifo_wr_en !== exp_wr) begin n_err++; $display("FAIL stall_wr_en c=%0d got=%b exp=%b", c, ifc.o_fifo_wr_en, exp_wr); end
      if (ifc.o_fifo_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL stall_extra_write c=%0d", c);
        end else begin
          e = exp_q.pop_front();
          n_cmp++; if (ifc.o_fifo_data !== e.data || ifc.o_ack !== 4'b0001) begin
            n_err++; $display("FAIL stall_word c=%0d data=%h ack=%b exp data=%h ack=0001", c, ifc.o_fifo_data, ifc.o_ack, e.data);
          end
        end
      end else begin
        n_cmp++; if (ifc.o_ack !== 4'b0000) begin n_err++; $display("FAIL stall_ack c=%0d got=%b exp=0000", c, ifc.o_ack); end
      end
      if (c == 7) begin n_cmp++; if (ifc.o_busy !== 1'b1) begin n_err++; $display("FAIL stall_busy got=%b exp=1", ifc.o_busy); end end
      if (c == 14) begin n_cmp++; if (ifc.o_busy !== 1'b0) begin n_err++; $display("FAIL stall_burst_end busy=%b exp=0", ifc.o_busy); end end
    end
    full_force = 1'b0;
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stall_missing got_left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_fifo_fill();
    logic          exp_wr;
    logic [DW-1:0] m;
    do_reset();
    use_fifo  = 1'b1;
    ifc.i_req = 4'b0011;
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < int'(MB); w++) mem_q.push_back(word_of(s, w));
    for (int c = 0; c < 40; c++) begin
      if (c != 0) adv();
      drive(); smp();
      exp_wr = (c >= 1 && c <= 8) || (c >= 10 && c <= 17);
      n_cmp++; if (ifc.o_fifo_wr_en !== exp_wr) begin n_err++; $display("FAIL fill_wr_en c=%0d got=%b exp=%b", c, ifc.o_fifo_wr_en, exp_wr); end
    end
    n_cmp++; if (ifc.o_busy !== 1'b1 || ifc.o_owner !== 2'd0) begin
      n_err++; $display("FAIL fill_stalled busy=%b owner=%0d exp busy=1 owner=0", ifc.o_busy, ifc.o_owner);
    end
    n_cmp++; if (wr_total != 16 || fcount != 16) begin n_err++; $display("FAIL fill_count writes=%0d stored=%0d exp=16", wr_total, fcount); end
    for (int i = 0; i < int'(DEPTH); i++) begin
      m = mem_q.pop_front();
      n_cmp++; if (mem[i] !== m) begin n_err++; $display("FAIL fill_mem[%0d] got=%h exp=%h", i, mem[i], m); end
    end
    use_fifo = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    ifc.i_req = 4'b1111;
    for (int c = 0; c < 13; c++) begin
      if (c != 0) adv();
      drive(); smp();
    end
    n_cmp++; if (ifc.o_owner !== 2'd1 || ifc.o_fifo_wr_en !== 1'b1) begin
      n_err++; $display("FAIL arst_pre owner=%0d wr=%b exp owner=1 wr=1", ifc.o_owner, ifc.o_fifo_wr_en);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_cmp++; if (ifc.o_fifo_wr_en !== 1'b0 || ifc.o_ack !== 4'b0000 || ifc.o_busy !== 1'b0 || ifc.o_owner !== 2'd0) begin
      n_err++; $display("FAIL arst_drop wr=%b ack=%b busy=%b owner=%0d exp all 0", ifc.o_fifo_wr_en, ifc.o_ack, ifc.o_busy, ifc.o_owner);
    end
    @(posedge clk);
    #1;
    rst   = 1'b1;
    ack_q = '0;
    drive(); smp();
    n_cmp++; if (ifc.o_busy !== 1'b0) begin n_err++; $display("FAIL arst_bubble busy=%b exp=0", ifc.o_busy); end
    adv(); drive(); smp();
    n_cmp++; if (ifc.o_busy !== 1'b1 || ifc.o_owner !== 2'd0 || ifc.o_ack !== 4'b0001) begin
      n_err++; $display("FAIL arst_regrant busy=%b owner=%0d ack=%b exp busy=1 owner=0 ack=0001", ifc.o_busy, ifc.o_owner, ifc.o_ack);
    end
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_round_robin();
    test_single_release();
    test_stall();
    test_fifo_fill();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
